// File: rtl/spi_flash_target_if.sv
// spi_flash_target_if: SPI pin and memory-port bundle for the flash responder.
// slave modport is the target side, master modport is the pins/memory side.
interface spi_flash_target_if;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;

  logic          spi_cs_n;
  logic          spi_sck;
  logic          spi_mosi;
  logic          spi_miso;
  logic          spi_miso_oe;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_valid;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_busy;
  logic          busy;
  logic          prog_done;
  logic          err;

  modport slave (
    input  spi_cs_n, spi_sck, spi_mosi, mem_rd_data, mem_busy,
    output spi_miso, spi_miso_oe, mem_rd_req, mem_rd_addr,
           mem_wr_valid, mem_wr_addr, mem_wr_data, busy, prog_done, err
  );

  modport master (
    output spi_cs_n, spi_sck, spi_mosi, mem_rd_data, mem_busy,
    input  spi_miso, spi_miso_oe, mem_rd_req, mem_rd_addr,
           mem_wr_valid, mem_wr_addr, mem_wr_data, busy, prog_done, err
  );
endinterface

// File: rtl/spi_flash_target.sv
// spi_flash_target: SPI mode-0 flash responder (READ/PROGRAM/RDSR/WREN/WRDI).
// SCK/CS_N/MOSI are oversampled in the clk domain; reads come from a
// fixed-latency memory port, program data streams to a write port.
// Optional feature: define SPI_TGT_FAST_READ_EN to decode 0x0B FAST_READ.
module spi_flash_target #(
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_flash_target_if.slave bus
);
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;

  localparam logic [DW-1:0] OP_PROG = 8'h02;
  localparam logic [DW-1:0] OP_READ = 8'h03;
  localparam logic [DW-1:0] OP_WRDI = 8'h04;
  localparam logic [DW-1:0] OP_RDSR = 8'h05;
  localparam logic [DW-1:0] OP_WREN = 8'h06;
`ifdef SPI_TGT_FAST_READ_EN
  localparam logic [DW-1:0] OP_FAST = 8'h0B;
`endif

  typedef enum logic [2:0] {
    IDLE, OPCODE, ADDR, RD_DATA, STATUS, WR_DATA, IGNORE, DUMMY
  } state_t;

  typedef enum logic [1:0] {CMD_READ, CMD_PROG, CMD_FAST} cmd_t;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_d1, sck_d1;
  logic                   cs_q, sck_q, mosi_q;
  logic                   sck_rise, sck_fall, cs_rise, byte_done;

  state_t        state;
  cmd_t          cmd;
  logic [2:0]    bit_cnt;
  logic [1:0]    addr_cnt;
  logic [6:0]    rx_shift;
  logic [DW-1:0] rx_byte;
  logic [AW-1:0] addr, addr_full;
  logic [DW-1:0] tx_shift, tx_next, pf_buf, ld_byte;
  logic          pf_valid, load_pend, wel, prog_ok, wr_any;
  logic [RD_LAT-1:0] rd_pipe;

  assign cs_q      = cs_sync[SYNC_STAGES-1];
  assign sck_q     = sck_sync[SYNC_STAGES-1];
  assign mosi_q    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_q & ~sck_d1;
  assign sck_fall  = ~sck_q & sck_d1;
  assign cs_rise   = cs_q & ~cs_d1;
  assign rx_byte   = {rx_shift, mosi_q};
  assign byte_done = sck_rise && (bit_cnt == 3'd0);
  assign addr_full = {addr[15:0], rx_byte};
  // Byte loaded on the first fall of an output byte; a missing prefetch reads as 0xFF.
  assign ld_byte   = (state == STATUS) ? tx_next : (pf_valid ? pf_buf : 8'hFF);

  // Input synchronizers and one-sample history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_d1     <= 1'b1;
      sck_d1    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      cs_d1     <= cs_q;
      sck_d1    <= sck_q;
    end
  end

  // Command FSM with byte dispatch, read prefetch and MISO shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cmd              <= CMD_READ;
      bit_cnt          <= 3'd7;
      addr_cnt         <= 2'd0;
      rx_shift         <= '0;
      addr             <= '0;
      tx_shift         <= '0;
      tx_next          <= '0;
      pf_buf           <= '0;
      pf_valid         <= 1'b0;
      load_pend        <= 1'b0;
      wel              <= 1'b0;
      prog_ok          <= 1'b0;
      wr_any           <= 1'b0;
      rd_pipe          <= '0;
      bus.spi_miso     <= 1'b0;
      bus.spi_miso_oe  <= 1'b0;
      bus.mem_rd_req   <= 1'b0;
      bus.mem_rd_addr  <= '0;
      bus.mem_wr_valid <= 1'b0;
      bus.mem_wr_addr  <= '0;
      bus.mem_wr_data  <= '0;
      bus.busy         <= 1'b0;
      bus.prog_done    <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      bus.mem_rd_req   <= 1'b0;
      bus.mem_wr_valid <= 1'b0;
      bus.prog_done    <= 1'b0;
      bus.err          <= 1'b0;
      bus.busy         <= ~cs_q;
      rd_pipe          <= RD_LAT'({rd_pipe, bus.mem_rd_req});
      if (rd_pipe[RD_LAT-1]) begin
        pf_buf   <= bus.mem_rd_data;
        pf_valid <= 1'b1;
      end

      if (cs_rise) begin
        state           <= IDLE;
        load_pend       <= 1'b0;
        bus.spi_miso    <= 1'b0;
        bus.spi_miso_oe <= 1'b0;
        if (bit_cnt != 3'd7) bus.err <= 1'b1;
        if ((state == WR_DATA) && prog_ok && wr_any) begin
          bus.prog_done <= 1'b1;
          wel           <= 1'b0;
        end
      end else if (state == IDLE) begin
        if (!cs_q) begin
          state     <= OPCODE;
          bit_cnt   <= 3'd7;
          addr_cnt  <= 2'd0;
          prog_ok   <= 1'b0;
          wr_any    <= 1'b0;
          pf_valid  <= 1'b0;
          load_pend <= 1'b0;
        end
      end else begin
        if (sck_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt - 3'd1;
        end

        if (byte_done) begin
          case (state)
            OPCODE: begin
              case (rx_byte)
                OP_READ: begin cmd <= CMD_READ; state <= ADDR; end
                OP_PROG: begin
                  cmd     <= CMD_PROG;
                  prog_ok <= wel & ~bus.mem_busy;
                  state   <= ADDR;
                end
`ifdef SPI_TGT_FAST_READ_EN
                OP_FAST: begin cmd <= CMD_FAST; state <= ADDR; end
`endif
                OP_RDSR: begin
                  tx_next   <= {6'b0, wel, bus.mem_busy};
                  load_pend <= 1'b1;
                  state     <= STATUS;
                end
                OP_WREN: begin wel <= 1'b1; state <= IGNORE; end
                OP_WRDI: begin wel <= 1'b0; state <= IGNORE; end
                default: state <= IGNORE;
              endcase
            end
            ADDR: begin
              addr     <= addr_full;
              addr_cnt <= addr_cnt + 2'd1;
              if (addr_cnt == 2'd2) begin
                case (cmd)
                  CMD_READ: begin
                    bus.mem_rd_req  <= 1'b1;
                    bus.mem_rd_addr <= addr_full;
                    addr            <= addr_full + AW'(1);
                    load_pend       <= 1'b1;
                    state           <= RD_DATA;
                  end
                  CMD_PROG: state <= WR_DATA;
                  default:  state <= DUMMY;
                endcase
              end
            end
            // Each byte boundary issues the read for the byte after the one going out.
            RD_DATA, DUMMY: begin
              bus.mem_rd_req  <= 1'b1;
              bus.mem_rd_addr <= addr;
              addr            <= addr + AW'(1);
              load_pend       <= 1'b1;
              state           <= RD_DATA;
            end
            STATUS: begin
              tx_next   <= {6'b0, wel, bus.mem_busy};
              load_pend <= 1'b1;
            end
            WR_DATA: begin
              if (prog_ok) begin
                bus.mem_wr_valid <= 1'b1;
                bus.mem_wr_addr  <= addr;
                bus.mem_wr_data  <= rx_byte;
                addr[7:0]        <= addr[7:0] + 8'd1;
                wr_any           <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        if (sck_fall && ((state == RD_DATA) || (state == STATUS))) begin
          if (load_pend) begin
            load_pend       <= 1'b0;
            bus.spi_miso_oe <= 1'b1;
            bus.spi_miso    <= ld_byte[7];
            tx_shift        <= {ld_byte[6:0], 1'b0};
            if (state == RD_DATA) begin
              pf_valid <= 1'b0;
              if (!pf_valid) bus.err <= 1'b1;
            end
          end else begin
            bus.spi_miso <= tx_shift[7];
            tx_shift     <= {tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end
endmodule
